// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, arbiter state encoding, ID-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Width of an index into n requesters; never below 1 bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set request after last_in, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller gates the grant with its own readiness.
// Ports: req_in (request vector), last_in (index served last),
//        gnt_out (one-hot or zero), idx_out (encoded grant), any_out (some request set).
module aes_rr_pick
    import aes_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req_in,
    input  logic [ID_W-1:0] last_in,
    output logic [N-1:0]    gnt_out,
    output logic [ID_W-1:0] idx_out,
    output logic            any_out
);

    logic found;

    // Two passes: indices above last_in first, then wrap to the ones at or below it.
    // This gives the requester just served the lowest priority.
    always_comb begin
        gnt_out = '0;
        idx_out = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_in[i] && (i > int'(last_in))) begin
                found      = 1'b1;
                gnt_out[i] = 1'b1;
                idx_out    = ID_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_in[i] && (i <= int'(last_in))) begin
                found      = 1'b1;
                gnt_out[i] = 1'b1;
                idx_out    = ID_W'(i);
            end
        end
        any_out = found;
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 core among NUM_REQ requesters, round-robin, one block in flight.
// Latency: handshake edge to rsp_valid_out is 2 + core latency cycles.
// Backpressure: req_ready_out only in IDLE; response held in RESP until rsp_ready_in.
// Ports: req_* per-requester block input, core_* start/done interface to the AES core,
//        rsp_* shared tagged response channel, busy_out high outside IDLE.
// Optional: define AES_ARB_TIMEOUT_EN for a core-done watchdog (TIMEOUT_CYCLES),
//           which reports an error response with zero data on expiry.
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = id_width(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         aes_clk_in,
    input  logic                         aes_rst_n_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    input  logic [NUM_REQ*AES_BLK_W-1:0] req_data_in,
    output logic                         core_start_out,
    output logic [AES_BLK_W-1:0]         core_data_out,
    input  logic                         core_done_in,
    input  logic [AES_BLK_W-1:0]         core_data_in,
    output logic                         rsp_valid_out,
    input  logic                         rsp_ready_in,
    output logic [ID_W-1:0]              rsp_id_out,
    output logic [AES_BLK_W-1:0]         rsp_data_out,
    output logic                         rsp_err_out,
    output logic                         busy_out
);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        last_grant_q, last_grant_d;
    logic                   core_start_q, core_start_d;
    logic [AES_BLK_W-1:0]   core_data_q, core_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
    logic [AES_BLK_W-1:0]   rsp_data_q, rsp_data_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_any;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   rsp_err_q, rsp_err_d;
`endif

    aes_rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_in  (req_valid_in),
        .last_in (last_grant_q),
        .gnt_out (pick_gnt),
        .idx_out (pick_idx),
        .any_out (pick_any)
    );

    // Grant is offered only in IDLE, so a handshake is simply "IDLE and someone valid".
    assign req_ready_out = (state_q == IDLE) ? pick_gnt : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        core_start_d = 1'b0;
        core_data_d  = core_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    core_data_d  = req_data_in[int'(pick_idx)*AES_BLK_W +: AES_BLK_W];
                    rsp_id_d     = pick_idx;
                    // Registered so the pulse coincides exactly with the ISSUE cycle.
                    core_start_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef AES_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT: begin
                // done is checked first so that done on the expiry edge wins.
                if (core_done_in) begin
                    rsp_data_d  = core_data_in;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef AES_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_data_d  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready_in) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aes_clk_in or negedge aes_rst_n_in) begin
        if (!aes_rst_n_in) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            core_start_q <= 1'b0;
            core_data_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            core_start_q <= core_start_d;
            core_data_q  <= core_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
`ifdef AES_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign core_start_out = core_start_q;
    assign core_data_out  = core_data_q;
    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_id_out     = rsp_id_q;
    assign rsp_data_out   = rsp_data_q;
    assign busy_out       = busy_q;
`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err_out    = rsp_err_q;
`else
    assign rsp_err_out    = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: reset, single block, round-robin, backpressure,
// reset mid-flight, fairness with dropped valid, and (with AES_ARB_TIMEOUT_EN) watchdog.
// Core is a behavioural model: known AES-128 answer for zero plaintext, ~pt otherwise.
module tb_aes_core_arbiter;
    import aes_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam logic [127:0] KAT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*128-1:0] req_data;
    logic             core_start;
    logic [127:0]     core_data_o;
    logic             core_done;
    logic [127:0]     core_data_i;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [127:0]     rsp_data;
    logic             rsp_err;
    logic             busy;

    always #5 clk = ~clk;

    aes_core_arbiter #(
        .NUM_REQ        (N),
        .ID_W           (IDW),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .aes_clk_in     (clk),
        .aes_rst_n_in   (rst_n),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_data_in    (req_data),
        .core_start_out (core_start),
        .core_data_out  (core_data_o),
        .core_done_in   (core_done),
        .core_data_in   (core_data_i),
        .rsp_valid_out  (rsp_valid),
        .rsp_ready_in   (rsp_ready),
        .rsp_id_out     (rsp_id),
        .rsp_data_out   (rsp_data),
        .rsp_err_out    (rsp_err),
        .busy_out       (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int starts = 0;
    int vld_cycles = 0;
    int hs_cyc = 0;
    int grant_q[$];
    int rid_q[$];
    logic [127:0] rdat_q[$];

    int core_lat = 10;
    bit core_mute = 1'b0;
    logic [127:0] core_pt;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] cipher(input logic [127:0] pt);
        return (pt == '0) ? KAT : ~pt;
    endfunction

    function automatic logic [127:0] blk(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done is sampled core_lat+2 edges after the handshake edge.
    initial begin
        core_done   = 1'b0;
        core_data_i = '0;
        forever begin
            @(negedge clk);
            if (core_start && !core_mute) begin
                core_pt = core_data_o;
                repeat (core_lat + 1) @(negedge clk);
                core_data_i = cipher(core_pt);
                core_done   = 1'b1;
                @(negedge clk);
                core_done   = 1'b0;
                core_data_i = '0;
            end
        end
    end

    // Monitor on the falling edge; stimulus moves 1 time unit after the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) starts++;
            if (rsp_valid) vld_cycles++;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    grant_q.push_back(i);
                    hs_cyc = cyc + 1;
                end
            end
            if (rsp_valid && rsp_ready) begin
                rid_q.push_back(int'(rsp_id));
                rdat_q.push_back(rsp_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Raise valid on requester idx and drop it right after its handshake edge.
    task automatic send(input int idx, input logic [127:0] d);
        int n0;
        bool_done: begin
            n0 = grant_q.size();
            req_data[idx*128 +: 128] = d;
            req_valid[idx] = 1'b1;
            for (int k = 0; k < 200; k++) begin
                tick();
                if (grant_q.size() > n0) begin
                    req_valid[idx] = 1'b0;
                    disable bool_done;
                end
            end
            req_valid[idx] = 1'b0;
            check_eq("send_timeout", 128'(0), 128'(1));
        end
    endtask

    task automatic wait_rsp(input int budget);
        int k;
        k = 0;
        while (!rsp_valid && k < budget) begin
            tick();
            k++;
        end
        if (!rsp_valid) check_eq("rsp_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int g0;
        int s0;
        int v0;
        logic [IDW-1:0] hid;
        logic [127:0] hdat;

        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        tick();
        // Reset state
        check_eq("rst_ready", 128'(req_ready), 128'(0));
        check_eq("rst_start", 128'(core_start), 128'(0));
        check_eq("rst_cdata", core_data_o, 128'(0));
        check_eq("rst_rvalid", 128'(rsp_valid), 128'(0));
        check_eq("rst_rid", 128'(rsp_id), 128'(0));
        check_eq("rst_rdata", rsp_data, 128'(0));
        check_eq("rst_rerr", 128'(rsp_err), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single block from requester 0, zero plaintext, 10-cycle core
        s0 = starts;
        send(0, 128'(0));
        check_eq("t1_busy", 128'(busy), 128'(1));
        wait_rsp(100);
        check_eq("t1_data", rsp_data, KAT);
        check_eq("t1_id", 128'(rsp_id), 128'(0));
        check_eq("t1_err", 128'(rsp_err), 128'(0));
        check_eq("t1_latency", 128'(cyc - hs_cyc), 128'(12));
        tick();
        check_eq("t1_resp_one_cycle", 128'(rsp_valid), 128'(0));
        check_eq("t1_starts", 128'(starts - s0), 128'(1));

        // All four valid continuously: grants rotate from requester 0
        do_reset();
        g0 = grant_q.size();
        v0 = rid_q.size();
        s0 = starts;
        for (int i = 0; i < N; i++) req_data[i*128 +: 128] = blk(i);
        req_valid = '1;
        for (int k = 0; k < 300 && rid_q.size() < v0 + 6; k++) tick();
        req_valid = '0;
        check_eq("t2_nrsp", 128'(rid_q.size() - v0), 128'(6));
        check_eq("t2_ngrant", 128'(grant_q.size() - g0), 128'(6));
        check_eq("t2_starts", 128'(starts - s0), 128'(6));
        for (int j = 0; j < 6; j++) begin
            if (grant_q.size() > g0 + j) check_eq($sformatf("t2_grant%0d", j), 128'(grant_q[g0 + j]), 128'(j % N));
            if (rid_q.size() > v0 + j) begin
                check_eq($sformatf("t2_rid%0d", j), 128'(rid_q[v0 + j]), 128'(j % N));
                check_eq($sformatf("t2_rdat%0d", j), rdat_q[v0 + j], cipher(blk(j % N)));
            end
        end

        // Backpressure: response held for 5 cycles, nothing new accepted or started
        do_reset();
        rsp_ready = 1'b0;
        send(1, blk(11));
        wait_rsp(100);
        hid = 2'd1;
        hdat = cipher(blk(11));
        s0 = starts;
        req_data[2*128 +: 128] = blk(12);
        req_valid[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq($sformatf("t3_valid%0d", k), 128'(rsp_valid), 128'(1));
            check_eq($sformatf("t3_id%0d", k), 128'(rsp_id), 128'(hid));
            check_eq($sformatf("t3_data%0d", k), rsp_data, hdat);
            check_eq($sformatf("t3_ready%0d", k), 128'(req_ready), 128'(0));
        end
        check_eq("t3_no_start", 128'(starts - s0), 128'(0));
        rsp_ready = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        check_eq("t3_released", 128'(rsp_valid), 128'(0));

        // Reset during WAIT, late done ignored, requester 0 first afterwards
        send(2, blk(22));
        repeat (4) tick();
        check_eq("t4_busy_wait", 128'(busy), 128'(1));
        v0 = vld_cycles;
        rst_n = 1'b0;
        tick();
        check_eq("t4_rst_busy", 128'(busy), 128'(0));
        check_eq("t4_rst_cdata", core_data_o, 128'(0));
        check_eq("t4_rst_rid", 128'(rsp_id), 128'(0));
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check_eq("t4_no_rsp", 128'(vld_cycles - v0), 128'(0));
        check_eq("t4_rvalid", 128'(rsp_valid), 128'(0));
        check_eq("t4_rdata", rsp_data, 128'(0));
        check_eq("t4_idle", 128'(busy), 128'(0));
        g0 = grant_q.size();
        req_data[0*128 +: 128] = blk(30);
        req_data[2*128 +: 128] = blk(32);
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        for (int k = 0; k < 20 && grant_q.size() == g0; k++) tick();
        req_valid = '0;
        if (grant_q.size() > g0) check_eq("t4_first_grant", 128'(grant_q[g0]), 128'(0));
        else check_eq("t4_grant_seen", 128'(0), 128'(1));
        wait_rsp(100);
        check_eq("t4_rsp_id", 128'(rsp_id), 128'(0));
        tick();

        // last_grant=2, requesters 2 and 3 valid -> 3; requester 1 drops valid unserved
        g0 = grant_q.size();
        send(2, blk(42));
        req_data[1*128 +: 128] = blk(41);
        req_valid[1] = 1'b1;
        repeat (3) tick();
        req_valid[1] = 1'b0;
        wait_rsp(100);
        tick();
        s0 = grant_q.size();
        req_data[3*128 +: 128] = blk(43);
        req_valid[2] = 1'b1;
        req_valid[3] = 1'b1;
        for (int k = 0; k < 20 && grant_q.size() == s0; k++) tick();
        req_valid = '0;
        if (grant_q.size() > s0) check_eq("t5_grant3", 128'(grant_q[s0]), 128'(3));
        else check_eq("t5_grant_seen", 128'(0), 128'(1));
        wait_rsp(100);
        check_eq("t5_rsp_id", 128'(rsp_id), 128'(3));
        check_eq("t5_rsp_data", rsp_data, cipher(blk(43)));
        tick();
        v0 = 0;
        for (int j = g0; j < grant_q.size(); j++) if (grant_q[j] == 1) v0++;
        check_eq("t5_req1_never", 128'(v0), 128'(0));

`ifdef AES_ARB_TIMEOUT_EN
        // Core never answers: error response after 64 WAIT cycles
        do_reset();
        core_mute = 1'b1;
        send(0, blk(50));
        wait_rsp(200);
        check_eq("tmo_err", 128'(rsp_err), 128'(1));
        check_eq("tmo_data", rsp_data, 128'(0));
        check_eq("tmo_latency", 128'(cyc - hs_cyc), 128'(65));
        tick();
        core_mute = 1'b0;
        // Done lands on the expiry edge: normal response wins
        core_lat = 63;
        send(1, blk(51));
        wait_rsp(200);
        check_eq("tmo_edge_err", 128'(rsp_err), 128'(0));
        check_eq("tmo_edge_data", rsp_data, cipher(blk(51)));
        check_eq("tmo_edge_latency", 128'(cyc - hs_cyc), 128'(65));
        tick();
        core_lat = 10;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES-128 encryption core among NUM_REQ requesters, e.g. the wishbone register front-end and DMA-style block feeders.
- Accepts 128-bit plaintext blocks over per-requester valid/ready handshakes and picks one requester round-robin.
- Sequences the core through a start pulse, then waits for done.
- Returns the ciphertext on a single shared response channel, tagged with the requester ID.
- Sits between the bus-side register blocks and the AES core, in the AES clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID (clog2(NUM_REQ), min 1).
- TIMEOUT_CYCLES, 64, core-done watchdog limit in cycles (only with AES_ARB_TIMEOUT_EN).

Ports:
- aes_clk_in  in  1  AES-domain clock; single clock for the whole block.
- aes_rst_n_in  in  1  asynchronous, active-low reset.
- req_valid_in  in  NUM_REQ  per-requester block valid.
- req_ready_out  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data_in  in  NUM_REQ*128  plaintext; requester i on bits [128*i+127:128*i].
- core_start_out  out  1  one-cycle start pulse to the core.
- core_data_out  out  128  plaintext to the core; held stable from start until done.
- core_done_in  in  1  one-cycle core completion pulse.
- core_data_in  in  128  ciphertext; valid while core_done_in=1.
- rsp_valid_out  out  1  response valid.
- rsp_ready_in  in  1  response accept.
- rsp_id_out  out  ID_W  index of the requester that owns the response.
- rsp_data_out  out  128  ciphertext.
- rsp_err_out  out  1  response is a timeout error (tied 0 without AES_ARB_TIMEOUT_EN).
- busy_out  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_out is combinational: a one-hot of the first valid requester, searching from last_grant+1 and wrapping modulo NUM_REQ.
  - A handshake completes on a clock edge where req_valid_in[g] and req_ready_out[g] are both 1.
  - On that edge: plaintext is captured into core_data_out, g is captured into rsp_id_out, and the FSM moves to ISSUE.
  - No valid requester: remain in IDLE.
- ISSUE:
  - core_start_out=1 for exactly this one cycle.
  - Next state WAIT.
- WAIT:
  - On core_done_in=1: capture core_data_in into rsp_data_out, set rsp_valid_out=1 (registered), go to RESP.
  - core_done_in is ignored in every state except WAIT.
- RESP:
  - Hold rsp_valid_out and the response fields until rsp_ready_in=1.
  - On that edge: clear rsp_valid_out, set last_grant = rsp_id_out, return to IDLE.
- Latency and throughput:
  - Minimum latency from request handshake to rsp_valid_out is 2 + core latency cycles.
  - Only one block is in flight at a time.
- Fairness:
  - A requester that was just served has lowest priority on the next pick.
  - With all requesters valid, grants rotate 0,1,2,3,0,…
- Boundary conditions:
  - req_ready_out is all-zero outside IDLE; requesters must hold valid and data until accepted.
  - A requester dropping req_valid_in before it is accepted is legal; that requester is simply not picked.
  - rsp_ready_in held high continuously: RESP lasts exactly one cycle.
  - Reset asserted mid-operation: immediate return to IDLE with all outputs cleared. The in-flight block is discarded; a core done arriving afterwards is ignored.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before core_done_in, the FSM goes to RESP with rsp_err_out=1 and rsp_data_out=0.
  - core_done_in arriving on the same edge as expiry wins: normal response, rsp_err_out=0.
- Without the macro: no counter is instantiated, WAIT waits indefinitely, and rsp_err_out is tied 0.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLK_W=128.
  - The arbiter state enum (IDLE/ISSUE/WAIT/RESP).
  - An ID-width helper function.
- One sub-module, aes_rr_pick: a combinational round-robin picker (inputs request vector and last_grant; outputs one-hot grant and encoded index). It is reusable by the other shared-resource blocks.

Test Plan:
- Single request: requester 0 sends plaintext 0, core model uses key 0 with 10-cycle latency -> rsp_data_out=66e94bd4ef8a2c3b884cfa59ca342b2e, rsp_id_out=0, rsp_valid_out 12 cycles after the handshake edge.
- All 4 requesters valid continuously with rsp_ready_in=1 -> grant order 0,1,2,3,0,1 and exactly one core_start_out per block.
- Backpressure: rsp_ready_in low for 5 cycles -> rsp_valid_out, id and data stable throughout; req_ready_out stays 0 and no second core_start_out is issued.
- Reset: aes_rst_n_in asserted in WAIT, then a late core_done_in -> outputs 0, state IDLE, no response emitted; the next request is served by requester 0 first.
- Requesters 2 and 3 valid with last_grant=2 -> requester 3 granted; a requester dropping valid before grant is never served.
- With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64: core never asserts done -> after 64 WAIT cycles, rsp_err_out=1 and rsp_data_out=0; done on the expiry edge -> normal response with err=0.
